dnn_accel_system_nios2_qsys_0_oci_dct_packer: RTL and testbench

Upstream producer for the Nios II OCI debug-trace sink in the DNN accelerator system. It packs a stream of 2-bit trace atoms into 30-bit words of up to 15 atoms and presents each word with its atom count (`dct_buffer`, `dct_count`) to the trace consumer. It also generates the end-of-test handshake, `test_ending` followed by `test_has_ended`. It provides upstream backpressure, plus flush and end-of-test sequencing.

---
 rtl/dnn_accel_system_nios2_qsys_0_oci_dct_packer_pkg.sv | 31 +++
 rtl/dnn_accel_system_nios2_qsys_0_oci_dct_packer_if.sv | 23 ++
 rtl/dnn_accel_system_nios2_qsys_0_oci_dct_packer_outreg.sv | 35 +++
 rtl/dnn_accel_system_nios2_qsys_0_oci_dct_packer.sv | 146 ++++++++++++++
 tb/tb_dnn_accel_system_nios2_qsys_0_oci_dct_packer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dnn_accel_system_nios2_qsys_0_oci_dct_packer_pkg.sv
// Shared constants, word type and slot-insert helper for the OCI debug-trace packer.
package dnn_accel_dct_pkg;

   localparam int DCT_SLOTS  = 15;
   localparam int DCT_ATOM_W = 2;
   localparam int DCT_BUF_W  = 30;
   localparam int DCT_CNT_W  = 4;
   localparam int DCT_OVF_W  = 8;

   typedef struct packed {
      logic [DCT_CNT_W-1:0] count;
      logic [DCT_BUF_W-1:0] buffer;
   } dct_word_t;

   // Writes one atom into the given slot, leaving every other slot untouched.
   function automatic logic [DCT_BUF_W-1:0] dct_slot_insert(
      input logic [DCT_BUF_W-1:0]  acc,
      input logic [DCT_CNT_W-1:0]  slot,
      input logic [DCT_ATOM_W-1:0] atom
   );
      logic [DCT_BUF_W-1:0] res;
      res = acc;
      for (int k = 0; k < DCT_SLOTS; k++) begin
         if (slot == DCT_CNT_W'(k)) begin
            res[k*DCT_ATOM_W +: DCT_ATOM_W] = atom;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dnn_accel_system_nios2_qsys_0_oci_dct_packer_if.sv
// Atom-in / word-out stream bundle of the trace packer.
interface dnn_accel_system_nios2_qsys_0_oci_dct_packer_if;
   import dnn_accel_dct_pkg::*;

   logic                  atom_valid;
   logic [DCT_ATOM_W-1:0] atom;
   logic                  atom_ready;
   logic [DCT_BUF_W-1:0]  dct_buffer;
   logic [DCT_CNT_W-1:0]  dct_count;
   logic                  dct_valid;
   logic                  dct_ready;

   modport master (
      input  atom_valid, atom, dct_ready,
      output atom_ready, dct_buffer, dct_count, dct_valid
   );

   modport slave (
      output atom_valid, atom, dct_ready,
      input  atom_ready, dct_buffer, dct_count, dct_valid
   );

endinterface

// File: rtl/dnn_accel_system_nios2_qsys_0_oci_dct_packer_outreg.sv
// Valid/ready holding register for a packed trace word.
module dnn_accel_dct_outreg
   import dnn_accel_dct_pkg::*;
(
   input  logic      clk,
   input  logic      reset_n,
   input  logic      load,
   input  dct_word_t load_word,
   input  logic      ready,
   output logic      valid,
   output dct_word_t word,
   output logic      out_free
);

   logic      valid_r;
   dct_word_t word_r;

   assign out_free = !valid_r || ready;
   assign valid    = valid_r;
   assign word     = word_r;

   // A load always wins over consumption so back-to-back words leave no bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_r <= 1'b0;
         word_r  <= '{count: {DCT_CNT_W{1'b0}}, buffer: {DCT_BUF_W{1'b0}}};
      end else if (load) begin
         valid_r <= 1'b1;
         word_r  <= load_word;
      end else if (valid_r && ready) begin
         valid_r <= 1'b0;
      end
   end

endmodule

// File: rtl/dnn_accel_system_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-slot words with flush and end-of-test sequencing.
// Define OCI_DCT_OVERFLOW_EN to drop (and count) atoms instead of backpressuring.
module dnn_accel_system_nios2_qsys_0_oci_dct_packer
   import dnn_accel_dct_pkg::*;
#(
   parameter int SLOTS  = DCT_SLOTS,
   parameter int ATOM_W = DCT_ATOM_W
) (
   input  logic clk,
   input  logic reset_n,
   dnn_accel_system_nios2_qsys_0_oci_dct_packer_if.master bus,
   input  logic flush,
   input  logic end_req,
   output logic test_ending,
   output logic test_has_ended
`ifdef OCI_DCT_OVERFLOW_EN
   ,
   output logic [DCT_OVF_W-1:0] dct_overflow_cnt
`endif
);

   localparam logic [DCT_CNT_W-1:0] CNT_ZERO = {DCT_CNT_W{1'b0}};
   localparam logic [DCT_CNT_W-1:0] CNT_ONE  = DCT_CNT_W'(1);
   localparam logic [DCT_CNT_W-1:0] CNT_FULL = DCT_CNT_W'(SLOTS);

   logic [DCT_BUF_W-1:0] acc_r, acc_n_s, base_acc_s;
   logic [DCT_CNT_W-1:0] acc_cnt_r, acc_cnt_n_s, base_cnt_s;
   logic [ATOM_W-1:0]    atom_s;
   logic                 flush_pend_r, flush_pend_n_s;
   logic                 end_pend_r, end_pend_n_s;
   logic                 run_r;
   logic                 test_ending_r, test_has_ended_r;
   logic                 ended_s, acc_full_s, move_s, out_free_s;
   logic                 can_store_s, accept_s, end_cond_s, dct_valid_s;
   dct_word_t            load_word_s, out_word_s;

   assign atom_s      = bus.atom;
   assign ended_s     = test_ending_r || test_has_ended_r;
   assign acc_full_s  = (acc_cnt_r == CNT_FULL);
   assign move_s      = out_free_s && (acc_full_s || (flush_pend_r && (acc_cnt_r != CNT_ZERO)));
   assign can_store_s = run_r && !ended_s && !flush_pend_r && (!acc_full_s || move_s);
   assign accept_s    = bus.atom_valid && can_store_s;
   assign load_word_s = '{count: acc_cnt_r, buffer: acc_r};
   assign end_cond_s  = end_pend_r && !ended_s && (acc_cnt_r == CNT_ZERO) && !dct_valid_s;

`ifdef OCI_DCT_OVERFLOW_EN
   logic [DCT_OVF_W-1:0] ovf_cnt_r;
   logic                 drop_s;

   assign bus.atom_ready   = run_r && !ended_s;
   assign drop_s           = bus.atom_valid && run_r && !ended_s && !can_store_s;
   assign dct_overflow_cnt = ovf_cnt_r;

   // Saturating count of atoms that found no room.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_cnt_r <= {DCT_OVF_W{1'b0}};
      end else if (drop_s && (ovf_cnt_r != {DCT_OVF_W{1'b1}})) begin
         ovf_cnt_r <= ovf_cnt_r + DCT_OVF_W'(1);
      end
   end
`else
   assign bus.atom_ready = can_store_s;
`endif

   dnn_accel_dct_outreg u_outreg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (move_s),
      .load_word (load_word_s),
      .ready     (bus.dct_ready),
      .valid     (dct_valid_s),
      .word      (out_word_s),
      .out_free  (out_free_s)
   );

   assign bus.dct_valid  = dct_valid_s;
   assign bus.dct_buffer = out_word_s.buffer;
   assign bus.dct_count  = out_word_s.count;
   assign test_ending    = test_ending_r;
   assign test_has_ended = test_has_ended_r;

   // Accumulator next state: a moved word empties acc so a same-edge atom lands in slot 0.
   always_comb begin
      base_acc_s  = acc_r;
      base_cnt_s  = acc_cnt_r;
      acc_n_s     = acc_r;
      acc_cnt_n_s = acc_cnt_r;
      if (move_s) begin
         base_acc_s = {DCT_BUF_W{1'b0}};
         base_cnt_s = CNT_ZERO;
      end else begin
         base_acc_s = acc_r;
         base_cnt_s = acc_cnt_r;
      end
      if (accept_s) begin
         acc_n_s     = dct_slot_insert(base_acc_s, base_cnt_s, atom_s);
         acc_cnt_n_s = base_cnt_s + CNT_ONE;
      end else begin
         acc_n_s     = base_acc_s;
         acc_cnt_n_s = base_cnt_s;
      end
   end

   // Flush/end bookkeeping; a pending end keeps the flush armed until the test ends.
   always_comb begin
      flush_pend_n_s = flush_pend_r;
      end_pend_n_s   = end_pend_r;
      if (ended_s) begin
         flush_pend_n_s = flush_pend_r;
      end else if (flush || end_req) begin
         flush_pend_n_s = 1'b1;
      end else if (flush_pend_r && !end_pend_r && (move_s || (acc_cnt_r == CNT_ZERO))) begin
         flush_pend_n_s = 1'b0;
      end else begin
         flush_pend_n_s = flush_pend_r;
      end
      if (!ended_s && end_req) begin
         end_pend_n_s = 1'b1;
      end else begin
         end_pend_n_s = end_pend_r;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_r            <= {DCT_BUF_W{1'b0}};
         acc_cnt_r        <= CNT_ZERO;
         flush_pend_r     <= 1'b0;
         end_pend_r       <= 1'b0;
         run_r            <= 1'b0;
         test_ending_r    <= 1'b0;
         test_has_ended_r <= 1'b0;
      end else begin
         acc_r            <= acc_n_s;
         acc_cnt_r        <= acc_cnt_n_s;
         flush_pend_r     <= flush_pend_n_s;
         end_pend_r       <= end_pend_n_s;
         run_r            <= 1'b1;
         test_ending_r    <= end_cond_s;
         test_has_ended_r <= test_has_ended_r || test_ending_r;
      end
   end

endmodule

// File: tb/tb_dnn_accel_system_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the OCI trace packer with a word scoreboard.
module tb_dnn_accel_system_nios2_qsys_0_oci_dct_packer;
   import dnn_accel_dct_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic flush = 1'b0;
   logic end_req = 1'b0;
   logic test_ending;
   logic test_has_ended;
`ifdef OCI_DCT_OVERFLOW_EN
   logic [7:0] dct_overflow_cnt;
`endif

   dnn_accel_system_nios2_qsys_0_oci_dct_packer_if bus ();

   dnn_accel_system_nios2_qsys_0_oci_dct_packer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .bus            (bus),
      .flush          (flush),
      .end_req        (end_req),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended)
`ifdef OCI_DCT_OVERFLOW_EN
      ,
      .dct_overflow_cnt (dct_overflow_cnt)
`endif
   );

   always #5 clk = ~clk;

   int        n_pass = 0;
   int        n_total = 0;
   int        n_fail = 0;
   dct_word_t sb[$];
   int        words_seen = 0;
   int        valid_cycles = 0;
   int        ending_cycles = 0;
   time       last_take = 0;
   time       te_time = 0;
   dct_word_t last_word;
   bit        mon_has;
   dct_word_t mon_exp;
   logic [29:0] m_buf = 30'h0;
   int        m_cnt = 0;
   time       t0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: compare every word the consumer takes.
   always @(negedge clk) begin
      if (bus.dct_valid) valid_cycles++;
      if (test_ending) begin
         ending_cycles++;
         te_time = $time;
      end
      if (reset_n && bus.dct_valid && bus.dct_ready) begin
         mon_has = (sb.size() != 0);
         check("sb_has_word", 64'(mon_has), 64'(1));
         if (mon_has) begin
            mon_exp = sb.pop_front();
            check("word_buffer", 64'(bus.dct_buffer), 64'(mon_exp.buffer));
            check("word_count", 64'(bus.dct_count), 64'(mon_exp.count));
         end
         last_word.buffer = bus.dct_buffer;
         last_word.count  = bus.dct_count;
         words_seen++;
         last_take = $time;
      end
   end

   task automatic model_push();
      dct_word_t w;
      w.buffer = m_buf;
      w.count  = 4'(m_cnt);
      sb.push_back(w);
      m_buf = 30'h0;
      m_cnt = 0;
   endtask

   task automatic model_add(input logic [1:0] a);
      m_buf[2*m_cnt +: 2] = a;
      m_cnt++;
      if (m_cnt == 15) model_push();
   endtask

   task automatic model_flush();
      if (m_cnt > 0) model_push();
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic put_atom(input logic [1:0] a);
      bit ok;
      ok = 1'b0;
      bus.atom_valid = 1'b1;
      bus.atom = a;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.atom_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("atom_accepted", 64'(ok), 64'(1));
      @(posedge clk);
      #1;
      bus.atom_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic pulse_end();
      end_req = 1'b1;
      @(posedge clk);
      #1;
      end_req = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 64'(bus.dct_valid), 64'(0));
      check({tag, "_buffer"}, 64'(bus.dct_buffer), 64'(0));
      check({tag, "_count"}, 64'(bus.dct_count), 64'(0));
      check({tag, "_atom_ready"}, 64'(bus.atom_ready), 64'(0));
      check({tag, "_test_ending"}, 64'(test_ending), 64'(0));
      check({tag, "_has_ended"}, 64'(test_has_ended), 64'(0));
   endtask

   initial begin
      bus.atom_valid = 1'b0;
      bus.atom = 2'b00;
      bus.dct_ready = 1'b0;
      #1 reset_n = 1'b0;
      #2;
      check_all_zero("reset");
      step(3);
      reset_n = 1'b1;
      step(1);

      // Full word of 2'b01 at full throughput.
      bus.dct_ready = 1'b1;
      valid_cycles = 0;
      words_seen = 0;
      t0 = $time;
      for (int i = 0; i < 15; i++) begin
         put_atom(2'b01);
         model_add(2'b01);
      end
      check("throughput_time", 64'($time - t0), 64'(150));
      step(3);
      check("full_words", 64'(words_seen), 64'(1));
      check("full_valid_cycles", 64'(valid_cycles), 64'(1));
      check("full_literal", 64'(last_word.buffer), 64'(30'h15555555));
      check("full_literal_cnt", 64'(last_word.count), 64'(15));

      // Partial word via flush, then a flush with nothing accumulated.
      words_seen = 0;
      put_atom(2'b01); model_add(2'b01);
      put_atom(2'b10); model_add(2'b10);
      put_atom(2'b11); model_add(2'b11);
      pulse_flush();
      model_flush();
      @(negedge clk);
      check("flush_latency_pre", 64'(bus.dct_valid), 64'(0));
      @(negedge clk);
      check("flush_latency", 64'(bus.dct_valid), 64'(1));
      check("flush_literal", 64'(bus.dct_buffer), 64'(30'h39));
      check("flush_literal_cnt", 64'(bus.dct_count), 64'(3));
      step(3);
      pulse_flush();
      step(4);
      check("empty_flush_no_word", 64'(words_seen), 64'(1));
      check("flush_sb_empty", 64'(sb.size()), 64'(0));

`ifndef OCI_DCT_OVERFLOW_EN
      // Backpressure: 30 atoms with the consumer stalled.
      bus.dct_ready = 1'b0;
      words_seen = 0;
      for (int i = 0; i < 30; i++) begin
         put_atom(2'b11);
         model_add(2'b11);
      end
      @(negedge clk);
      check("bp_atom_ready", 64'(bus.atom_ready), 64'(0));
      check("bp_held_valid", 64'(bus.dct_valid), 64'(1));
      check("bp_held_buffer", 64'(bus.dct_buffer), 64'(30'h3FFFFFFF));
      check("bp_held_count", 64'(bus.dct_count), 64'(15));
      step(3);
      @(negedge clk);
      check("bp_atom_ready_hold", 64'(bus.atom_ready), 64'(0));
      step(1);
      bus.dct_ready = 1'b1;
      step(4);
      check("bp_words", 64'(words_seen), 64'(2));
      check("bp_sb_empty", 64'(sb.size()), 64'(0));
`else
      // Overflow: 40 atoms with the consumer stalled, 10 of them dropped.
      bus.dct_ready = 1'b0;
      words_seen = 0;
      for (int i = 0; i < 40; i++) begin
         put_atom(2'b11);
         if (i < 30) model_add(2'b11);
      end
      @(negedge clk);
      check("ovf_count", 64'(dct_overflow_cnt), 64'(10));
      check("ovf_atom_ready", 64'(bus.atom_ready), 64'(1));
      step(1);
      bus.dct_ready = 1'b1;
      step(4);
      check("ovf_words", 64'(words_seen), 64'(2));
      check("ovf_sb_empty", 64'(sb.size()), 64'(0));
`endif

      // Reset with a held word and 7 atoms accumulated.
      bus.dct_ready = 1'b0;
      for (int i = 0; i < 22; i++) put_atom(2'b10);
      @(negedge clk);
      check("pre_reset_valid", 64'(bus.dct_valid), 64'(1));
      step(1);
      reset_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
`ifdef OCI_DCT_OVERFLOW_EN
      check("mid_reset_ovf", 64'(dct_overflow_cnt), 64'(0));
`endif
      sb.delete();
      m_buf = 30'h0;
      m_cnt = 0;
      step(2);
      reset_n = 1'b1;
      step(2);
      words_seen = 0;
      bus.dct_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         put_atom(2'(i % 4));
         model_add(2'(i % 4));
      end
      step(3);
      check("post_reset_words", 64'(words_seen), 64'(1));
      check("post_reset_literal", 64'(last_word.buffer), 64'(30'h24E4E4E4));
      check("post_reset_sb_empty", 64'(sb.size()), 64'(0));

      // End of test after a 4-atom partial word.
      words_seen = 0;
      ending_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         put_atom(2'(i));
         model_add(2'(i));
      end
      pulse_end();
      model_flush();
      for (int i = 0; i < 50 && !test_has_ended; i++) @(negedge clk);
      check("end_has_ended", 64'(test_has_ended), 64'(1));
      check("end_words", 64'(words_seen), 64'(1));
      check("end_word_count", 64'(last_word.count), 64'(4));
      check("end_word_literal", 64'(last_word.buffer), 64'(30'hE4));
      check("end_pulse_cycles", 64'(ending_cycles), 64'(1));
      check("end_after_consume", 64'(te_time >= last_take + 20), 64'(1));
      step(1);
      bus.atom_valid = 1'b1;
      bus.atom = 2'b01;
      pulse_flush();
      pulse_end();
      step(3);
      @(negedge clk);
      check("end_atom_ready", 64'(bus.atom_ready), 64'(0));
      check("end_sticky", 64'(test_has_ended), 64'(1));
      check("end_single_pulse", 64'(ending_cycles), 64'(1));
      check("end_no_more_words", 64'(words_seen), 64'(1));
      bus.atom_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
